// File: rtl/ahb_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_if
// Purpose : groups the AHB-Lite slave-side and APB master-side signals of
//           the AHB-to-APB bridge into one bundle.
// Signals : AHB  - HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA (to bridge)
//                  HREADYOUT, HRESP, HRDATA (from bridge)
//           APB  - PSEL, PENABLE, PWRITE, PADDR, PWDATA (from bridge)
//                  PRDATA, PREADY, PSLVERR (to bridge)
// Modports: slave  - the bridge's view
//           master - the view of whatever drives the bridge (system/bench)
// ---------------------------------------------------------------------------
interface ahb_apb_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic                  HREADY;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic [31:0]           HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        output HREADYOUT, HRESP, HRDATA,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        input  HREADYOUT, HRESP, HRDATA,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
// Purpose : AHB-Lite slave to APB master bridge. Each selected NONSEQ/SEQ
//           transfer becomes one APB SETUP/ACCESS sequence; AHB wait states
//           are inserted until PREADY, and PSLVERR becomes a two-cycle AHB
//           ERROR response. All outputs are registered.
// Ports   : HCLK   - clock, rising edge
//           HRESET - synchronous active-high reset
//           bus    - ahb_apb_bridge_if.slave (AHB slave + APB master signals)
// Options : AHB_APB_TIMEOUT_EN - when defined, an ACCESS phase that sees
//           PREADY low for TIMEOUT_CYCLES counted cycles is terminated with
//           the ERROR response. When undefined, ACCESS waits indefinitely.
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_apb_bridge_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t                state;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;

    logic accept;
    logic timeout;

    // HSIZE is ignored (APB is always word wide); upper/lower address bits
    // and HTRANS[0] carry no information for this bridge.
    logic unused_bits;
    assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:ADDR_WIDTH], bus.HADDR[1:0], bus.HTRANS[0]};

    // IDLE/BUSY (HTRANS[1]=0) never start an APB access.
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

`ifdef AHB_APB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign timeout = (wait_cnt == 16'(TIMEOUT_CYCLES));

    // Cleared while in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !bus.PREADY) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        paddr     <= {bus.HADDR[ADDR_WIDTH-1:2], 2'b00};
                        pwrite    <= bus.HWRITE;
                        hreadyout <= 1'b0;
                        if (bus.HWRITE) begin
                            state <= WDATA;
                        end else begin
                            // Reads go straight to SETUP, so PSEL rises now.
                            psel  <= 1'b1;
                            state <= SETUP;
                        end
                    end
                end
                WDATA: begin
                    // HWDATA is valid in the data phase, one cycle after accept.
                    pwdata <= bus.HWDATA;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (bus.PSLVERR) begin
                            hresp <= 1'b1;
                            state <= ERR1;
                        end else begin
                            hreadyout <= 1'b1;
                            if (!pwrite) begin
                                hrdata <= bus.PRDATA;
                            end
                            state <= IDLE;
                        end
                    end else if (timeout) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        hresp   <= 1'b1;
                        state   <= ERR1;
                    end
                end
                ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                ERR2: begin
                    hresp <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = hrdata;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PADDR     = paddr;
    assign bus.PWDATA    = pwdata;

endmodule
